frame_sequencer: RTL and testbench

Timing and sequencing controller for the image-readout datapath. It walks a stored image of IMAGE_WIDTH x IMAGE_HEIGHT pixels two pixels per clock and produces the signals the pixel reader and threshold stage consume: pair address, row/column, line/frame pulses and end-of-frame flag. It inserts a start-of-frame delay and a per-line horizontal blanking delay, and runs one frame per start request.

---
 rtl/img_pkg.sv | 42 ++++
 rtl/delay_counter.sv | 26 ++
 rtl/frame_sequencer.sv | 127 ++++++++++++
 tb/tb_frame_sequencer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/img_pkg.sv
// Shared image-pipeline definitions: sequencer state type, default geometry
// and delays, and the width helpers used by the reader/threshold blocks.
package img_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START_WAIT,
        ST_ACTIVE,
        ST_HBLANK,
        ST_DONE
    } state_t;

    localparam int DEF_IMAGE_WIDTH      = 768;
    localparam int DEF_IMAGE_HEIGHT     = 512;
    localparam int DEF_START_DELAY      = 100;
    localparam int DEF_HORIZONTAL_DELAY = 160;

    // $clog2 clamped to 1 so degenerate geometries still get a real bit
    function automatic int clog2_min1(input int v);
        int r;
        r = $clog2(v);
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int addr_w(input int w, input int h);
        return clog2_min1(w * h);
    endfunction

    function automatic int row_w(input int h);
        return clog2_min1(h);
    endfunction

    function automatic int col_w(input int w);
        return clog2_min1(w);
    endfunction

    // one counter serves both delays, so size it for the larger one
    function automatic int cnt_w(input int a, input int b);
        return $clog2((a > b) ? a : b) + 1;
    endfunction

endpackage

// File: rtl/delay_counter.sv
// Loadable down-counter with zero flag; stops at zero.
module delay_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    // load has priority; otherwise count down and park at zero
    always_ff @(posedge clk) begin
        if (reset)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_load_val;
        else if (r_cnt != '0)
            r_cnt <= r_cnt - W'(1);
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/frame_sequencer.sv
// Frame sequencer: walks the image two pixels per clock with start and
// per-line blanking delays, one frame per accepted start.
module frame_sequencer
    import img_pkg::*;
#(
    parameter  int IMAGE_WIDTH      = DEF_IMAGE_WIDTH,
    parameter  int IMAGE_HEIGHT     = DEF_IMAGE_HEIGHT,
    parameter  int START_DELAY      = DEF_START_DELAY,
    parameter  int HORIZONTAL_DELAY = DEF_HORIZONTAL_DELAY,
    localparam int ADDR_W           = addr_w(IMAGE_WIDTH, IMAGE_HEIGHT),
    localparam int ROW_W            = row_w(IMAGE_HEIGHT),
    localparam int COL_W            = col_w(IMAGE_WIDTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              pause,
    output logic              busy,
    output logic              pixel_valid,
    output logic [ADDR_W-1:0] pix_addr,
    output logic [ROW_W-1:0]  row,
    output logic [COL_W-1:0]  col,
    output logic              vertical_Pulse,
    output logic              horizontal_Pulse,
    output logic              done_Flag
);

    localparam int               CNT_W    = cnt_w(START_DELAY, HORIZONTAL_DELAY);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMAGE_WIDTH - 2);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMAGE_HEIGHT - 1);
    localparam logic [CNT_W-1:0] SW_LOAD  = CNT_W'(START_DELAY - 1);
    localparam logic [CNT_W-1:0] HB_LOAD  = CNT_W'(HORIZONTAL_DELAY - 1);

    state_t              r_state, w_next;
    logic                r_paused;
    logic [ADDR_W-1:0]   r_addr;
    logic [ROW_W-1:0]    r_row;
    logic [COL_W-1:0]    r_col;
    logic                w_load, w_zero, w_valid, w_accept;
    logic [CNT_W-1:0]    w_load_val;

    delay_counter #(.W(CNT_W)) u_delay (
        .clk       (clk),
        .reset     (reset),
        .i_load    (w_load),
        .i_load_val(w_load_val),
        .o_zero    (w_zero)
    );

    // a pair is emitted whenever ACTIVE and the previous edge saw no pause
    assign w_valid  = (r_state == ST_ACTIVE) && !r_paused;
    assign w_accept = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && start;

    // next-state and delay-counter load decode
    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_load_val = '0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_next     = ST_START_WAIT;
                    w_load     = 1'b1;
                    w_load_val = SW_LOAD;
                end
            end
            ST_START_WAIT: begin
                if (w_zero) w_next = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (w_valid && (r_col == LAST_COL)) begin
                    if (r_row == LAST_ROW) begin
                        w_next = ST_DONE;
                    end else begin
                        w_next     = ST_HBLANK;
                        w_load     = 1'b1;
                        w_load_val = HB_LOAD;
                    end
                end
            end
            ST_HBLANK: begin
                if (w_zero) w_next = ST_ACTIVE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // state, pause capture and pixel position counters
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_paused <= 1'b0;
            r_addr   <= '0;
            r_row    <= '0;
            r_col    <= '0;
        end else begin
            r_state  <= w_next;
            // pause only matters while staying in ACTIVE; entering ACTIVE is never stalled
            r_paused <= (r_state == ST_ACTIVE) && (w_next == ST_ACTIVE) && pause;
            if (w_accept) begin
                r_addr <= '0;
                r_row  <= '0;
                r_col  <= '0;
            end else if (w_valid) begin
                if (r_col != LAST_COL) begin
                    r_col  <= r_col + COL_W'(2);
                    r_addr <= r_addr + ADDR_W'(2);
                end else if (r_row != LAST_ROW) begin
                    r_col  <= '0;
                    r_row  <= r_row + ROW_W'(1);
                    r_addr <= r_addr + ADDR_W'(2);
                end
            end
        end
    end

    assign busy             = (r_state == ST_START_WAIT) || (r_state == ST_ACTIVE) ||
                              (r_state == ST_HBLANK);
    assign pixel_valid      = w_valid;
    assign pix_addr         = r_addr;
    assign row              = r_row;
    assign col              = r_col;
    assign vertical_Pulse   = (r_state == ST_ACTIVE) || (r_state == ST_HBLANK);
    assign horizontal_Pulse = (r_state == ST_ACTIVE);
    assign done_Flag        = (r_state == ST_DONE);

endmodule

// File: tb/tb_frame_sequencer.sv
// Bench for frame_sequencer: 8x4 image (delays 3/2) and 2x1 image (delay 1).
module tb_frame_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, a_start, a_pause, b_start, b_pause;
    logic       a_busy, a_valid, a_vp, a_hp, a_done;
    logic [4:0] a_addr;
    logic [1:0] a_row;
    logic [2:0] a_col;
    logic       b_busy, b_valid, b_vp, b_hp, b_done;
    logic [0:0] b_addr, b_row, b_col;

    frame_sequencer #(.IMAGE_WIDTH(8), .IMAGE_HEIGHT(4), .START_DELAY(3),
                      .HORIZONTAL_DELAY(2)) dut_a (
        .clk(clk), .reset(reset), .start(a_start), .pause(a_pause),
        .busy(a_busy), .pixel_valid(a_valid), .pix_addr(a_addr), .row(a_row),
        .col(a_col), .vertical_Pulse(a_vp), .horizontal_Pulse(a_hp),
        .done_Flag(a_done));

    frame_sequencer #(.IMAGE_WIDTH(2), .IMAGE_HEIGHT(1), .START_DELAY(1),
                      .HORIZONTAL_DELAY(1)) dut_b (
        .clk(clk), .reset(reset), .start(b_start), .pause(b_pause),
        .busy(b_busy), .pixel_valid(b_valid), .pix_addr(b_addr), .row(b_row),
        .col(b_col), .vertical_Pulse(b_vp), .horizontal_Pulse(b_hp),
        .done_Flag(b_done));

    int checks = 0;
    int failures = 0;

    typedef struct { int addr; int row; int col; } pair_t;
    pair_t qA[$];
    pair_t qB[$];

    typedef struct {
        int c; int busy; int valid; int addr; int row; int col; int hp; int vp; int done;
    } vec_t;
    vec_t tbl0[$];
    vec_t tblp[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0d exp=%0d", name, $time, act, exp);
        end
    endtask

    function automatic vec_t mk(input int c, input int busy, input int valid, input int addr,
                                input int row, input int col, input int hp, input int vp,
                                input int done);
        vec_t v;
        v.c = c; v.busy = busy; v.valid = valid; v.addr = addr; v.row = row;
        v.col = col; v.hp = hp; v.vp = vp; v.done = done;
        return v;
    endfunction

    task automatic check_vec(input vec_t v);
        chk($sformatf("c%0d_busy", v.c),  int'(a_busy),  v.busy);
        chk($sformatf("c%0d_valid", v.c), int'(a_valid), v.valid);
        chk($sformatf("c%0d_addr", v.c),  int'(a_addr),  v.addr);
        chk($sformatf("c%0d_row", v.c),   int'(a_row),   v.row);
        chk($sformatf("c%0d_col", v.c),   int'(a_col),   v.col);
        chk($sformatf("c%0d_hpulse", v.c), int'(a_hp),   v.hp);
        chk($sformatf("c%0d_vpulse", v.c), int'(a_vp),   v.vp);
        chk($sformatf("c%0d_done", v.c),  int'(a_done),  v.done);
    endtask

    // one clock; afterwards we sit 1 time unit into the next cycle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame_a();
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++)
                qA.push_back('{r * 8 + 2 * k, r, 2 * k});
    endtask

    // cycle c inputs are sampled at the edge that ends cycle c
    task automatic run_frame(input int ncyc, input logic [63:0] smask,
                             input logic [63:0] pmask, input int sel);
        push_frame_a();
        for (int c = 0; c <= ncyc; c++) begin
            if (sel == 0) begin
                foreach (tbl0[i]) if (tbl0[i].c == c) check_vec(tbl0[i]);
            end else begin
                foreach (tblp[i]) if (tblp[i].c == c) check_vec(tblp[i]);
            end
            a_start = smask[c];
            a_pause = pmask[c];
            tick();
        end
        a_start = 1'b0;
        a_pause = 1'b0;
        chk("sbA_drained", qA.size(), 0);
    endtask

    // scoreboards: every emitted pair must be the next expected one
    always @(negedge clk) begin
        if (!reset && a_valid) begin
            if (qA.size() == 0) chk("sbA_extra_pair", int'(a_addr), -1);
            else begin
                pair_t e;
                e = qA.pop_front();
                chk("sbA_addr", int'(a_addr), e.addr);
                chk("sbA_row", int'(a_row), e.row);
                chk("sbA_col", int'(a_col), e.col);
            end
        end
        if (!reset && b_valid) begin
            if (qB.size() == 0) chk("sbB_extra_pair", int'(b_addr), -1);
            else begin
                pair_t e;
                e = qB.pop_front();
                chk("sbB_addr", int'(b_addr), e.addr);
                chk("sbB_row", int'(b_row), e.row);
                chk("sbB_col", int'(b_col), e.col);
            end
        end
    end

    initial begin
        //              c  busy vld addr row col hp vp done
        tbl0.push_back(mk(0,  0, 0,  0, 0, 0, 0, 0, 0));
        tbl0.push_back(mk(1,  1, 0,  0, 0, 0, 0, 0, 0));
        tbl0.push_back(mk(3,  1, 0,  0, 0, 0, 0, 0, 0));
        tbl0.push_back(mk(4,  1, 1,  0, 0, 0, 1, 1, 0));
        tbl0.push_back(mk(7,  1, 1,  6, 0, 6, 1, 1, 0));
        tbl0.push_back(mk(8,  1, 0,  8, 1, 0, 0, 1, 0));
        tbl0.push_back(mk(9,  1, 0,  8, 1, 0, 0, 1, 0));
        tbl0.push_back(mk(10, 1, 1,  8, 1, 0, 1, 1, 0));
        tbl0.push_back(mk(25, 1, 1, 30, 3, 6, 1, 1, 0));
        tbl0.push_back(mk(26, 0, 0, 30, 3, 6, 0, 0, 1));
        tbl0.push_back(mk(30, 0, 0, 30, 3, 6, 0, 0, 1));

        tblp.push_back(mk(0,  0, 0, 30, 3, 6, 0, 0, 1));
        tblp.push_back(mk(1,  1, 0,  0, 0, 0, 0, 0, 0));
        tblp.push_back(mk(5,  1, 1,  2, 0, 2, 1, 1, 0));
        tblp.push_back(mk(6,  1, 0,  4, 0, 4, 1, 1, 0));
        tblp.push_back(mk(7,  1, 0,  4, 0, 4, 1, 1, 0));
        tblp.push_back(mk(8,  1, 1,  4, 0, 4, 1, 1, 0));
        tblp.push_back(mk(27, 1, 1, 30, 3, 6, 1, 1, 0));
        tblp.push_back(mk(28, 0, 0, 30, 3, 6, 0, 0, 1));

        reset = 1'b1; a_start = 1'b0; a_pause = 1'b0; b_start = 1'b0; b_pause = 1'b0;
        tick();
        tick();
        chk("rst_busy", int'(a_busy), 0);
        chk("rst_valid", int'(a_valid), 0);
        chk("rst_done", int'(a_done), 0);
        chk("rst_addr", int'(a_addr), 0);
        chk("rstB_busy", int'(b_busy), 0);
        reset = 1'b0;
        tick();

        // plain frame from IDLE
        run_frame(30, 64'h1, 64'h0, 0);
        // start from DONE, pause at edges 5 and 6
        run_frame(30, 64'h1, 64'h60, 1);

        // reset during row 1, with start also high: reset wins
        push_frame_a();
        for (int c = 0; c < 12; c++) begin
            a_start = (c == 0);
            tick();
        end
        chk("pre_rst_valid", int'(a_valid), 1);
        chk("pre_rst_addr", int'(a_addr), 12);
        chk("pre_rst_row", int'(a_row), 1);
        reset = 1'b1;
        a_start = 1'b1;
        tick();
        reset = 1'b0;
        a_start = 1'b0;
        chk("midrst_busy", int'(a_busy), 0);
        chk("midrst_valid", int'(a_valid), 0);
        chk("midrst_vpulse", int'(a_vp), 0);
        chk("midrst_hpulse", int'(a_hp), 0);
        chk("midrst_done", int'(a_done), 0);
        chk("midrst_addr", int'(a_addr), 0);
        chk("midrst_row", int'(a_row), 0);
        chk("midrst_col", int'(a_col), 0);
        qA.delete();
        tick();

        // fresh frame with extra starts in START_WAIT, ACTIVE, HBLANK
        run_frame(30, 64'h125, 64'h0, 0);

        // single-row 2x1 image
        qB.push_back('{0, 0, 0});
        for (int c = 0; c <= 4; c++) begin
            if (c == 1) begin
                chk("B_c1_busy", int'(b_busy), 1);
                chk("B_c1_valid", int'(b_valid), 0);
            end
            if (c == 2) begin
                chk("B_c2_valid", int'(b_valid), 1);
                chk("B_c2_hpulse", int'(b_hp), 1);
                chk("B_c2_addr", int'(b_addr), 0);
            end
            if (c == 3) begin
                chk("B_c3_done", int'(b_done), 1);
                chk("B_c3_busy", int'(b_busy), 0);
                chk("B_c3_valid", int'(b_valid), 0);
                chk("B_c3_vpulse", int'(b_vp), 0);
            end
            b_start = (c == 0);
            tick();
        end
        b_start = 1'b0;
        chk("sbB_drained", qB.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
